// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_stall_unit : stall / bubble / flush control for the 5-stage pipeline
// Revision 1.0
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
   parameter int CNT_WIDTH = 32,
   parameter int MAX_STALL = 16
) (
   input  logic                 CLOCK,
   input  logic                 RESET,
   input  logic [5:0]           OpcodeID_IN,
   input  logic [5:0]           FunctID_IN,
   input  logic [4:0]           IDRegisterRS_IN,
   input  logic [4:0]           IDRegisterRT_IN,
   input  logic [4:0]           writeRDIDEXE,
   input  logic                 writeEnableIDEXE,
   input  logic                 MemReadIDEXE,
   input  logic [4:0]           writeRDEXEMEM,
   input  logic                 MemReadEXEMEM,
   input  logic                 AltPCEnable_IN,
   input  logic                 DMEM_BUSY,
   output logic                 STALL_OUT,
   output logic                 BUBBLE_OUT,
   output logic                 FLUSH_OUT,
   output logic [1:0]           State_OUT,
   output logic [CNT_WIDTH-1:0] StallCount_OUT,
   output logic [CNT_WIDTH-1:0] FlushCount_OUT,
   output logic                 ERROR_OUT
);

   localparam int                RUN_W     = $clog2(MAX_STALL + 2);
   localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(MAX_STALL + 1);

   typedef enum logic [1:0] {
      ST_RUN         = 2'd0,
      ST_LOAD_USE    = 2'd1,
      ST_BRANCH_WAIT = 2'd2,
      ST_MEM_WAIT    = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
   logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
   logic [RUN_W-1:0]     run_q, run_d;
   logic                 error_q, error_d;

   logic is_branch, uses_rs, uses_rt;
   logic rs_match_e, rt_match_e, rs_match_m, rt_match_m;
   logic load_use, branch_wait, stall;

   always_comb begin
      is_branch = (OpcodeID_IN == 6'd1) || (OpcodeID_IN == 6'd4) || (OpcodeID_IN == 6'd5) ||
                  (OpcodeID_IN == 6'd6) || (OpcodeID_IN == 6'd7) ||
                  ((OpcodeID_IN == 6'd0) && ((FunctID_IN == 6'd8) || (FunctID_IN == 6'd9)));
      uses_rs   = !((OpcodeID_IN == 6'd2) || (OpcodeID_IN == 6'd3) || (OpcodeID_IN == 6'd15));
      uses_rt   = (OpcodeID_IN == 6'd0)  || (OpcodeID_IN == 6'd4)  || (OpcodeID_IN == 6'd5) ||
                  (OpcodeID_IN == 6'd40) || (OpcodeID_IN == 6'd41) || (OpcodeID_IN == 6'd43);

      // Register 0 is hard-wired, so a write to it never creates a dependency.
      rs_match_e = uses_rs && (IDRegisterRS_IN != 5'd0) &&
                   (IDRegisterRS_IN == writeRDIDEXE) && writeEnableIDEXE;
      rt_match_e = uses_rt && (IDRegisterRT_IN != 5'd0) &&
                   (IDRegisterRT_IN == writeRDIDEXE) && writeEnableIDEXE;
      rs_match_m = uses_rs && (IDRegisterRS_IN != 5'd0) &&
                   (IDRegisterRS_IN == writeRDEXEMEM) && MemReadEXEMEM;
      rt_match_m = uses_rt && (IDRegisterRT_IN != 5'd0) &&
                   (IDRegisterRT_IN == writeRDEXEMEM) && MemReadEXEMEM;

      load_use    = MemReadIDEXE && (rs_match_e || rt_match_e);
      branch_wait = is_branch && (rs_match_e || rt_match_e || rs_match_m || rt_match_m);
      stall       = load_use || branch_wait || DMEM_BUSY;
   end

   assign STALL_OUT  = stall;
   assign BUBBLE_OUT = (load_use || branch_wait) && !DMEM_BUSY;
   assign FLUSH_OUT  = AltPCEnable_IN && !stall;

   always_comb begin
      if (DMEM_BUSY)        state_d = ST_MEM_WAIT;
      else if (load_use)    state_d = ST_LOAD_USE;
      else if (branch_wait) state_d = ST_BRANCH_WAIT;
      else                  state_d = ST_RUN;

      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1))
         stall_count_d = stall_count_q + CNT_WIDTH'(1);

      flush_count_d = flush_count_q;
      if (FLUSH_OUT && (flush_count_q != '1))
         flush_count_d = flush_count_q + CNT_WIDTH'(1);

      // Run length of consecutive stall cycles; parks at the limit.
      run_d = run_q;
      if (!stall)                  run_d = '0;
      else if (run_q != RUN_LIMIT) run_d = run_q + RUN_W'(1);

      error_d = error_q || (run_d == RUN_LIMIT);
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= ST_RUN;
         stall_count_q <= '0;
         flush_count_q <= '0;
         run_q         <= '0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
         run_q         <= run_d;
         error_q       <= error_d;
      end
   end

   assign State_OUT      = state_q;
   assign StallCount_OUT = stall_count_q;
   assign FlushCount_OUT = flush_count_q;
   assign ERROR_OUT      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// tb_hazard_stall_unit : directed scenarios plus random stimulus against a reference model.
module tb_hazard_stall_unit;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b0;
   logic [5:0] op, fn;
   logic [4:0] rs, rt, wr_e, wr_m;
   logic       we_e, mr_e, mr_m, alt, busy;

   logic        stall, bubble, flush, err;
   logic [1:0]  state;
   logic [31:0] scnt, fcnt;
   logic        s_stall, s_bubble, s_flush, s_err;
   logic [1:0]  s_state;
   logic [3:0]  s_scnt, s_fcnt;

   int     n_checks = 0, n_fail = 0;
   int     m_state, m_run;
   longint m_sc, m_fc, m_ssc, m_sfc;
   bit     m_err;

   hazard_stall_unit #(.CNT_WIDTH(32), .MAX_STALL(16)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .OpcodeID_IN(op), .FunctID_IN(fn),
      .IDRegisterRS_IN(rs), .IDRegisterRT_IN(rt), .writeRDIDEXE(wr_e),
      .writeEnableIDEXE(we_e), .MemReadIDEXE(mr_e), .writeRDEXEMEM(wr_m),
      .MemReadEXEMEM(mr_m), .AltPCEnable_IN(alt), .DMEM_BUSY(busy),
      .STALL_OUT(stall), .BUBBLE_OUT(bubble), .FLUSH_OUT(flush), .State_OUT(state),
      .StallCount_OUT(scnt), .FlushCount_OUT(fcnt), .ERROR_OUT(err));

   hazard_stall_unit #(.CNT_WIDTH(4), .MAX_STALL(16)) dut_small (
      .CLOCK(CLOCK), .RESET(RESET), .OpcodeID_IN(op), .FunctID_IN(fn),
      .IDRegisterRS_IN(rs), .IDRegisterRT_IN(rt), .writeRDIDEXE(wr_e),
      .writeEnableIDEXE(we_e), .MemReadIDEXE(mr_e), .writeRDEXEMEM(wr_m),
      .MemReadEXEMEM(mr_m), .AltPCEnable_IN(alt), .DMEM_BUSY(busy),
      .STALL_OUT(s_stall), .BUBBLE_OUT(s_bubble), .FLUSH_OUT(s_flush), .State_OUT(s_state),
      .StallCount_OUT(s_scnt), .FlushCount_OUT(s_fcnt), .ERROR_OUT(s_err));

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: hazards from the list of source registers the instruction reads.
   function automatic void model_comb(output bit st, output bit bu, output bit fl, output int nxt);
      int  srcs[$];
      bit  br, lu, bw;
      lu = 1'b0;
      bw = 1'b0;
      br = (op inside {6'd1, 6'd4, 6'd5, 6'd6, 6'd7}) || (op == 6'd0 && (fn == 6'd8 || fn == 6'd9));
      if (!(op inside {6'd2, 6'd3, 6'd15}))                     srcs.push_back(int'(rs));
      if (op inside {6'd0, 6'd4, 6'd5, 6'd40, 6'd41, 6'd43})    srcs.push_back(int'(rt));
      foreach (srcs[i]) begin
         if (srcs[i] != 0 && srcs[i] == int'(wr_e) && we_e) begin
            if (mr_e) lu = 1'b1;
            if (br)   bw = 1'b1;
         end
         if (srcs[i] != 0 && srcs[i] == int'(wr_m) && mr_m && br) bw = 1'b1;
      end
      st  = lu || bw || busy;
      bu  = (lu || bw) && !busy;
      fl  = alt && !st;
      nxt = busy ? 3 : lu ? 1 : bw ? 2 : 0;
   endfunction

   function automatic longint inc_sat(input longint v, input bit en, input longint mx);
      return (en && v < mx) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_run = 0; m_err = 1'b0;
      m_sc = 0; m_fc = 0; m_ssc = 0; m_sfc = 0;
   endtask

   task automatic idle();
      op = 6'd0; fn = 6'd32; rs = 5'd0; rt = 5'd0; wr_e = 5'd0; wr_m = 5'd0;
      we_e = 1'b0; mr_e = 1'b0; mr_m = 1'b0; alt = 1'b0; busy = 1'b0;
   endtask

   // Inputs are applied just after an edge; check, then advance one clock.
   task automatic cycle();
      bit st, bu, fl;
      int nxt;
      #2;
      model_comb(st, bu, fl, nxt);
      check("stall",       stall,  st);
      check("bubble",      bubble, bu);
      check("flush",       flush,  fl);
      check("state",       state,  m_state);
      check("stall_count", scnt,   m_sc);
      check("flush_count", fcnt,   m_fc);
      check("error",       err,    m_err);
      check("small_stall_count", s_scnt, m_ssc);
      check("small_flush_count", s_fcnt, m_sfc);
      check("small_error", s_err,  m_err);
      @(posedge CLOCK);
      if (RESET) begin
         m_state = nxt;
         m_sc  = inc_sat(m_sc,  st, 64'hFFFF_FFFF);
         m_fc  = inc_sat(m_fc,  fl, 64'hFFFF_FFFF);
         m_ssc = inc_sat(m_ssc, st, 15);
         m_sfc = inc_sat(m_sfc, fl, 15);
         m_run = st ? ((m_run + 1 > 17) ? 17 : m_run + 1) : 0;
         if (m_run == 17) m_err = 1'b1;
      end
      #1;
   endtask

   task automatic check_regs_zero(input string tag);
      check({tag, "_state"}, state, 0);
      check({tag, "_stall_count"}, scnt, 0);
      check({tag, "_flush_count"}, fcnt, 0);
      check({tag, "_error"}, err, 0);
      check({tag, "_small_count"}, s_scnt, 0);
   endtask

   task automatic do_reset();
      #2 RESET = 1'b0;
      #1;
      model_reset();
      check_regs_zero("async_reset");
      @(posedge CLOCK);
      #1 RESET = 1'b1;
   endtask

   localparam int N_OPS = 14;
   int ops[N_OPS] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 15, 35, 40, 41, 43};
   int regs[4]    = '{0, 8, 9, 10};
   int functs[4]  = '{8, 9, 32, 0};

   initial begin
      idle();
      model_reset();
      @(posedge CLOCK);
      #1;
      check_regs_zero("power_on_reset");
      RESET = 1'b1;

      // load-use: lw $8 in EXE, add reading $8 in ID
      idle(); wr_e = 5'd8; we_e = 1'b1; mr_e = 1'b1; rs = 5'd8; rt = 5'd3;
      cycle();
      wr_e = 5'd0; we_e = 1'b0; mr_e = 1'b0; wr_m = 5'd8; mr_m = 1'b1;
      cycle();
      check("load_use_state", state, 0);

      // load feeding a branch: two stall cycles, then a taken branch flushes once
      idle(); op = 6'd4; rs = 5'd9; wr_e = 5'd9; we_e = 1'b1; mr_e = 1'b1; alt = 1'b1;
      cycle();
      wr_e = 5'd0; we_e = 1'b0; mr_e = 1'b0; wr_m = 5'd9; mr_m = 1'b1;
      cycle();
      check("branch_wait_state", state, 2);
      wr_m = 5'd0; mr_m = 1'b0;
      cycle();
      check("branch_flush_count", fcnt, 1);
      idle();
      cycle();

      // register zero never matches
      idle(); wr_e = 5'd0; we_e = 1'b1; mr_e = 1'b1; rs = 5'd0;
      cycle();

      // memory wait over a pending load-use
      idle(); wr_e = 5'd8; we_e = 1'b1; mr_e = 1'b1; rs = 5'd8; busy = 1'b1;
      repeat (3) cycle();
      check("mem_wait_state", state, 3);
      busy = 1'b0;
      cycle();
      check("after_mem_wait_state", state, 1);
      idle();
      cycle();

      // watchdog: 17 consecutive stall cycles, flag is sticky
      idle(); busy = 1'b1;
      repeat (16) cycle();
      check("watchdog_not_yet", err, 0);
      cycle();
      check("watchdog_set", err, 1);
      busy = 1'b0;
      repeat (2) cycle();
      check("watchdog_sticky", err, 1);
      busy = 1'b1;
      repeat (3) cycle();
      do_reset();

      // narrow counter saturates
      idle(); busy = 1'b1;
      repeat (20) cycle();
      busy = 1'b0;
      cycle();
      check("small_count_saturated", s_scnt, 15);
      check("wide_count_not_saturated", scnt, 20);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         op   = 6'(ops[$urandom_range(N_OPS - 1)]);
         fn   = 6'(functs[$urandom_range(3)]);
         rs   = 5'(regs[$urandom_range(3)]);
         rt   = 5'(regs[$urandom_range(3)]);
         wr_e = 5'(regs[$urandom_range(3)]);
         wr_m = 5'(regs[$urandom_range(3)]);
         we_e = 1'($urandom_range(1));
         mr_e = 1'($urandom_range(1));
         mr_m = 1'($urandom_range(1));
         alt  = ($urandom_range(2) == 0);
         busy = ($urandom_range(7) == 0);
         if (i == 200) do_reset();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
